fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the decoder. Holds the PC,

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect and
// the decode-side instruction handshake. The fetch unit uses the master modport.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc, fetch_misaligned,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc, fetch_misaligned,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited in-order imem reads, small instruction FIFO.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise a flag.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthC = (CntW + 1)'(BUF_DEPTH);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d, resp_pc_q, resp_pc_d, target;
  logic [CntW-1:0] count_q, count_d, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     word_mem_q [BUF_DEPTH];
  logic [31:0]     pc_mem_q   [BUF_DEPTH];
  logic [CntW:0]   occupancy;
  logic            halted, req_valid, req_fire, dropping, push, pop, inst_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      misaligned_q <= |bus.redirect_pc[1:0];
    end
  end

  assign target               = bus.redirect_pc;
  assign halted               = misaligned_q;
  assign bus.fetch_misaligned = misaligned_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb  = ^bus.redirect_pc[1:0];
  assign target               = {bus.redirect_pc[31:2], 2'b00};
  assign halted               = 1'b0;
  assign bus.fetch_misaligned = 1'b0;
`endif

  // Requests are credit-limited so every in-flight response is guaranteed a FIFO slot.
  assign occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
  assign req_valid  = (state_q == StRun) && !bus.redirect_valid && !halted &&
                      (occupancy < DepthC);
  assign req_fire   = req_valid && bus.imem_req_ready;
  assign dropping   = (drop_cnt_q != '0);
  assign push       = bus.imem_resp_valid && !dropping && !bus.redirect_valid;
  assign inst_valid = (count_q != '0) && !bus.redirect_valid;
  assign pop        = inst_valid && bus.inst_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid;
  assign bus.instruction    = word_mem_q[rd_ptr_q];
  assign bus.inst_pc        = pc_mem_q[rd_ptr_q];

  always_comb begin
    state_d       = StRun;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(bus.imem_resp_valid);
    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle's response must be discarded.
      pc_d       = target;
      resp_pc_d  = target;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = outstanding_q - CntW'(bus.imem_resp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.imem_resp_valid && dropping) drop_cnt_d = drop_cnt_q - 1'b1;
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem_q[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with variable latency, second
// instance checks RESET_PC wrap-around.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_ready = 1'b0;
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;
  int due;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_q[$];
  logic [31:0] got_pc_q[$];
  logic [31:0] got_inst_q[$];
  logic [31:0] acc2_q[$];
  logic        pend2 = 1'b0;
  logic [31:0] pend2_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: drive responses at negedge, sample handshakes just before posedge.
  always @(negedge clk) begin
    cyc++;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
    bus.imem_req_ready   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bus2.imem_resp_valid = pend2;
    bus2.imem_resp_data  = mem_word(pend2_addr);
    #3;
    if (rst) begin
      mq_addr.delete(); mq_due.delete(); acc_q.delete();
      got_pc_q.delete(); got_inst_q.delete(); acc2_q.delete();
      pend2 = 1'b0;
      last_due = 0;
    end else begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        due = cyc + int'($urandom_range(lat_min, lat_max));
        if (due < last_due) due = last_due;
        last_due = due;
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(due);
        acc_q.push_back(bus.imem_req_addr);
      end
      if (bus.inst_valid && bus.inst_ready) begin
        got_pc_q.push_back(bus.inst_pc);
        got_inst_q.push_back(bus.instruction);
      end
      pend2      = bus2.imem_req_valid && bus2.imem_req_ready;
      pend2_addr = bus2.imem_req_addr;
      if (pend2) acc2_q.push_back(bus2.imem_req_addr);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    acc_q.delete(); got_pc_q.delete(); got_inst_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    @(negedge clk); #2;
    checks++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: req_valid=%b inst_valid=%b want 0 0",
                         bus.imem_req_valid, bus.inst_valid);
    end
    checks++;
    if (bus.fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_misaligned: got %b want 0", bus.fetch_misaligned);
    end
    @(negedge clk);
    rst = 1'b0;
    #2;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL boot_no_req: got %b want 0", bus.imem_req_valid);
    end
    @(negedge clk); #2;
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: valid=%b addr=%h want 1 00000000",
                         bus.imem_req_valid, bus.imem_req_addr);
    end
    @(negedge clk); #2;
    checks++;
    if (bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL early_inst_valid: got %b want 0", bus.inst_valid);
    end
    @(negedge clk); #2;
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.instruction !== mem_word(0)) begin
      errors++; $display("FAIL first_inst: valid=%b pc=%h inst=%h want 1 00000000 %h",
                         bus.inst_valid, bus.inst_pc, bus.instruction, mem_word(0));
    end
  endtask

  task automatic test_stream();
    repeat (40) @(negedge clk);
    #4;
    checks++;
    if (acc_q.size() < 10 || got_pc_q.size() < 10) begin
      errors++; $display("FAIL stream_progress: acc=%0d got=%0d want >=10 each",
                         acc_q.size(), got_pc_q.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (acc_q[i] !== 32'(4 * i) || got_pc_q[i] !== 32'(4 * i) ||
            got_inst_q[i] !== mem_word(32'(4 * i))) begin
          errors++; $display("FAIL stream_%0d: addr=%h pc=%h inst=%h want %h", i, acc_q[i],
                             got_pc_q[i], got_inst_q[i], 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] head;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    #4;
    head = got_pc_q[$] + 32'd4;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_no_req: got %b want 0", bus.imem_req_valid);
    end
    checks++;
    if (acc_q.size() - got_pc_q.size() !== 2) begin
      errors++; $display("FAIL stall_buffered: got %0d want 2", acc_q.size() - got_pc_q.size());
    end
    checks++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== head || bus.instruction !== mem_word(head)) begin
      errors++; $display("FAIL stall_head: valid=%b pc=%h inst=%h want 1 %h %h", bus.inst_valid,
                         bus.inst_pc, bus.instruction, head, mem_word(head));
    end
    @(negedge clk);
    bus.inst_ready = 1'b1;
    repeat (20) @(negedge clk);
    #4;
    for (int i = 1; i < got_pc_q.size(); i++) begin
      checks++;
      if (got_pc_q[i] !== got_pc_q[i-1] + 32'd4 || got_inst_q[i] !== mem_word(got_pc_q[i])) begin
        errors++; $display("FAIL release_seq_%0d: pc=%h inst=%h want %h", i, got_pc_q[i],
                           got_inst_q[i], got_pc_q[i-1] + 32'd4);
      end
    end
    // Redirect while the FIFO is full: output must be masked that cycle.
    @(negedge clk);
    bus.inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    clear_logs();
    #2;
    checks++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_mask: inst_valid=%b req_valid=%b want 0 0",
                         bus.inst_valid, bus.imem_req_valid);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    repeat (12) @(negedge clk);
    #4;
    checks++;
    if (got_pc_q.size() < 2 || got_pc_q[0] !== 32'h40 || got_inst_q[0] !== mem_word(32'h40) ||
        got_pc_q[1] !== 32'h44) begin
      errors++; $display("FAIL redirect_full_target: n=%0d pc0=%h pc1=%h want 00000040 00000044",
                         got_pc_q.size(), got_pc_q[0], got_pc_q[1]);
    end
  endtask

  task automatic wait_two_accepts(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #4;
      if (acc_q.size() >= 2) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL %s_timeout: accepts=%0d want 2", name, acc_q.size());
    end
  endtask

  task automatic test_redirect();
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_two_accepts("redirect");
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    clear_logs();
    #2;
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL redirect_no_req: got %b want 0", bus.imem_req_valid);
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    repeat (30) @(negedge clk);
    #4;
    checks++;
    if (acc_q.size() < 1 || acc_q[0] !== 32'h100) begin
      errors++; $display("FAIL redirect_addr: n=%0d addr=%h want 00000100", acc_q.size(), acc_q[0]);
    end
    checks++;
    if (got_pc_q.size() < 2 || got_pc_q[0] !== 32'h100 || got_inst_q[0] !== mem_word(32'h100) ||
        got_pc_q[1] !== 32'h104 || got_inst_q[1] !== mem_word(32'h104)) begin
      errors++; $display("FAIL redirect_drop: n=%0d pc0=%h inst0=%h want 00000100 %h",
                         got_pc_q.size(), got_pc_q[0], got_inst_q[0], mem_word(32'h100));
    end
  endtask

  task automatic test_back_to_back();
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_two_accepts("b2b");
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    clear_logs();
    @(negedge clk);
    bus.redirect_pc = 32'h500;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b1;
    repeat (30) @(negedge clk);
    #4;
    checks++;
    if (got_pc_q.size() < 2 || got_pc_q[0] !== 32'h500 || got_inst_q[0] !== mem_word(32'h500) ||
        got_pc_q[1] !== 32'h504 || acc_q[0] !== 32'h500) begin
      errors++; $display("FAIL b2b_redirect: n=%0d pc0=%h inst0=%h addr0=%h want 00000500",
                         got_pc_q.size(), got_pc_q[0], got_inst_q[0], acc_q[0]);
    end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_random();
    lat_min = 1; lat_max = 3; rand_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 20000 && got_pc_q.size() < 1000; i++) begin
      @(negedge clk);
      bus.inst_ready = 1'($urandom_range(0, 1));
    end
    #4;
    checks++;
    if (got_pc_q.size() < 1000) begin
      errors++; $display("FAIL random_timeout: got %0d want 1000", got_pc_q.size());
    end else begin
      for (int i = 0; i < 1000; i++) begin
        checks++;
        if (got_pc_q[i] !== 32'(4 * i) || got_inst_q[i] !== mem_word(32'(4 * i))) begin
          errors++; $display("FAIL random_%0d: pc=%h inst=%h want %h %h", i, got_pc_q[i],
                             got_inst_q[i], 32'(4 * i), mem_word(32'(4 * i)));
        end
      end
    end
    lat_min = 1; lat_max = 1; rand_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (10) @(negedge clk);
    #4;
    checks++;
    if (acc2_q.size() < 3 || acc2_q[0] !== 32'hFFFF_FFF8 || acc2_q[1] !== 32'hFFFF_FFFC ||
        acc2_q[2] !== 32'h0000_0000) begin
      errors++; $display("FAIL wrap_addrs: n=%0d a0=%h a1=%h a2=%h want FFFFFFF8 FFFFFFFC 00000000",
                         acc2_q.size(), acc2_q[0], acc2_q[1], acc2_q[2]);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    bus.inst_ready = 1'b1;
    repeat (8) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    clear_logs();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    #2;
    checks++;
    if (bus.fetch_misaligned !== 1'b1) begin
      errors++; $display("FAIL misalign_flag: got %b want 1", bus.fetch_misaligned);
    end
    repeat (10) @(negedge clk);
    #4;
    checks++;
    if (acc_q.size() !== 0 || got_pc_q.size() !== 0 || bus.inst_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_halt: accepts=%0d insts=%0d want 0 0",
                         acc_q.size(), got_pc_q.size());
    end
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    clear_logs();
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #2;
    checks++;
    if (bus.fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL misalign_clear: got %b want 0", bus.fetch_misaligned);
    end
    repeat (10) @(negedge clk);
    #4;
    checks++;
    if (acc_q.size() < 1 || got_pc_q.size() < 1 || acc_q[0] !== 32'h200 ||
        got_pc_q[0] !== 32'h200) begin
      errors++; $display("FAIL misalign_resume: addr=%h pc=%h want 00000200", acc_q[0], got_pc_q[0]);
    end
`else
    #2;
    checks++;
    if (bus.fetch_misaligned !== 1'b0) begin
      errors++; $display("FAIL misalign_flag: got %b want 0", bus.fetch_misaligned);
    end
    repeat (10) @(negedge clk);
    #4;
    checks++;
    if (acc_q.size() < 1 || got_pc_q.size() < 1 || acc_q[0] !== 32'h100 ||
        got_pc_q[0] !== 32'h100 || got_inst_q[0] !== mem_word(32'h100)) begin
      errors++; $display("FAIL misalign_align: addr=%h pc=%h want 00000100", acc_q[0], got_pc_q[0]);
    end
`endif
  endtask

  initial begin
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.inst_ready     = 1'b1;
    bus2.imem_req_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_random();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
